// File: rtl/huc_timer_pkg.sv
// Shared constants for the HuC6280 interval timer: register offsets, widths and defaults.
package huc_timer_pkg;

  localparam int unsigned PRESCALE_DEF = 1024;
  localparam int unsigned CNT_W        = 7;

  localparam logic TMR_OFS_COUNT = 1'b0;
  localparam logic TMR_OFS_CTRL  = 1'b1;

  localparam int unsigned TMR_CTRL_EN = 0;

endpackage

// File: rtl/huc_timer_prescaler.sv
// Modulo-PRESCALE cycle counter with sync clear and enable; tick strobes on the wrap cycle.
module huc_timer_prescaler #(
  parameter int unsigned PRESCALE = 1024,
  parameter int unsigned PS_W     = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam logic [PS_W-1:0] PsLast = PS_W'(PRESCALE - 1);

  logic [PS_W-1:0] ps_q, ps_d;

  // Clear has priority so a restart never coincides with a tick.
  always_comb begin
    ps_d = ps_q;
    tick = 1'b0;
    if (clr) begin
      ps_d = '0;
    end else if (en) begin
      if (ps_q == PsLast) begin
        ps_d = '0;
        tick = 1'b1;
      end else begin
        ps_d = ps_q + PS_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ps_q <= '0;
    end else begin
      ps_q <= ps_d;
    end
  end

endmodule

// File: rtl/huc_timer.sv
// HuC6280 interval timer: 7-bit prescaled down-counter raising level TIQ on underflow.
// Define HUC_TIMER_ACK_ON_READ_EN to also clear the pending IRQ on a counter read.
module huc_timer
  import huc_timer_pkg::*;
#(
  parameter int unsigned PRESCALE = PRESCALE_DEF,
  parameter int unsigned PS_W     = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       CET_n,
  input  logic       RE,
  input  logic       WE,
  input  logic       RDY,
  input  logic       addr0,
  input  logic [7:0] d_in,
  input  logic       irq_ack,
  output logic [7:0] d_out,
  output logic       TIQ
);

  logic [CNT_W-1:0] reload_q, reload_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             en_q, en_d;
  logic             irq_q, irq_d;

  logic wr, wr_cnt, wr_ctrl, restart, tick, underflow, irq_clr;
  logic unused_d_in;

  assign unused_d_in = d_in[7];

  assign wr      = ~CET_n & WE & RDY;
  assign wr_cnt  = wr & (addr0 == TMR_OFS_COUNT);
  assign wr_ctrl = wr & (addr0 == TMR_OFS_CTRL);
  assign restart = wr_ctrl & d_in[TMR_CTRL_EN] & ~en_q;

  huc_timer_prescaler #(
    .PRESCALE (PRESCALE),
    .PS_W     (PS_W)
  ) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .clr   (restart),
    .en    (en_q),
    .tick  (tick)
  );

  assign underflow = tick & (cnt_q == '0);

`ifdef HUC_TIMER_ACK_ON_READ_EN
  assign irq_clr = irq_ack | (~CET_n & RE & RDY & (addr0 == TMR_OFS_COUNT));
`else
  assign irq_clr = irq_ack;
`endif

  // Underflow uses the pre-edge reload value, so a coincident reload write applies next time.
  always_comb begin
    reload_d = wr_cnt ? d_in[CNT_W-1:0] : reload_q;
    en_d     = wr_ctrl ? d_in[TMR_CTRL_EN] : en_q;
    cnt_d    = cnt_q;
    if (restart) begin
      cnt_d = reload_q;
    end else if (tick) begin
      cnt_d = underflow ? reload_q : cnt_q - CNT_W'(1);
    end
    irq_d = underflow | (irq_q & ~irq_clr);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      reload_q <= '0;
      cnt_q    <= '0;
      en_q     <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      reload_q <= reload_d;
      cnt_q    <= cnt_d;
      en_q     <= en_d;
      irq_q    <= irq_d;
    end
  end

  assign TIQ = irq_q;

  always_comb begin
    d_out = 8'h00;
    if (~CET_n & RE) begin
      if (addr0 == TMR_OFS_COUNT) begin
        d_out = {1'b0, cnt_q};
      end else begin
        d_out = {7'b0, en_q};
      end
    end
  end

endmodule

// File: tb/tb_huc_timer.sv
// Directed self-checking bench for huc_timer, run with a short prescale to keep runs brief.
module tb_huc_timer;

  localparam int P = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       CET_n = 1'b1;
  logic       RE = 1'b0;
  logic       WE = 1'b0;
  logic       RDY = 1'b1;
  logic       addr0 = 1'b0;
  logic [7:0] d_in = 8'h00;
  logic       irq_ack = 1'b0;
  logic [7:0] d_out;
  logic       TIQ;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  huc_timer #(
    .PRESCALE (P),
    .PS_W     (4)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .CET_n   (CET_n),
    .RE      (RE),
    .WE      (WE),
    .RDY     (RDY),
    .addr0   (addr0),
    .d_in    (d_in),
    .irq_ack (irq_ack),
    .d_out   (d_out),
    .TIQ     (TIQ)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) step();
  endtask

  task automatic wr(input logic a, input logic [7:0] d);
    CET_n = 1'b0; WE = 1'b1; RDY = 1'b1; addr0 = a; d_in = d;
    step();
    CET_n = 1'b1; WE = 1'b0; d_in = 8'h00;
  endtask

  task automatic rd(input logic a, output logic [7:0] v);
    CET_n = 1'b0; RE = 1'b1; addr0 = a;
    #1;
    v = d_out;
    CET_n = 1'b1; RE = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
  endtask

  task automatic wait_tiq(input int budget, input string name);
    int n;
    n = 0;
    while (TIQ !== 1'b1 && n < budget) begin
      step();
      n++;
    end
    checks++;
    if (TIQ !== 1'b1) begin
      errors++;
      $display("FAIL %s: TIQ got %b want 1 within %0d cycles", name, TIQ, budget);
    end
  endtask

  task automatic test_reset();
    logic [7:0] v;
    #1;
    checks++;
    if (TIQ !== 1'b0) begin errors++; $display("FAIL rst_tiq: got %b want 0", TIQ); end
    checks++;
    if (d_out !== 8'h00) begin errors++; $display("FAIL rst_dout: got %h want 00", d_out); end
    reset = 1'b0;
    step();
    wr(1'b0, 8'h05);
    wr(1'b1, 8'h01);
    repeat (2 * P + 3) step();
    rd(1'b0, v);
    checks++;
    if (v !== 8'h03) begin errors++; $display("FAIL rst_precount: got %h want 03", v); end
    reset = 1'b1;
    #1;
    rd(1'b0, v);
    checks++;
    if (v !== 8'h00) begin errors++; $display("FAIL rst_mid_cnt: got %h want 00", v); end
    rd(1'b1, v);
    checks++;
    if (v !== 8'h00) begin errors++; $display("FAIL rst_mid_en: got %h want 00", v); end
    checks++;
    if (TIQ !== 1'b0) begin errors++; $display("FAIL rst_mid_tiq: got %b want 0", TIQ); end
    step();
    reset = 1'b0;
    repeat (3 * P) step();
    rd(1'b0, v);
    checks++;
    if (v !== 8'h00) begin errors++; $display("FAIL rst_no_resume: got %h want 00", v); end
    wr(1'b1, 8'h01);
    rd(1'b0, v);
    checks++;
    if (v !== 8'h00) begin errors++; $display("FAIL rst_reload_cleared: got %h want 00", v); end
    wr(1'b1, 8'h00);
  endtask

  task automatic test_basic_and_ack();
    logic [7:0] v;
    int e0, t1, t2;
    do_reset();
    wr(1'b0, 8'h02);
    wr(1'b1, 8'h01);
    e0 = cyc;
    rd(1'b0, v);
    checks++;
    if (v !== 8'h02) begin errors++; $display("FAIL basic_cnt2: got %h want 02", v); end
    wait_until(e0 + P);
    rd(1'b0, v);
    checks++;
    if (v !== 8'h01) begin errors++; $display("FAIL basic_cnt1: got %h want 01", v); end
    wait_until(e0 + 2 * P);
    rd(1'b0, v);
    checks++;
    if (v !== 8'h00) begin errors++; $display("FAIL basic_cnt0: got %h want 00", v); end
    wait_tiq(4 * P, "basic_tiq");
    t1 = cyc;
    checks++;
    if (t1 - e0 != 3 * P) begin
      errors++; $display("FAIL basic_period: got %0d want %0d", t1 - e0, 3 * P);
    end
    rd(1'b0, v);
    checks++;
    if (v !== 8'h02) begin errors++; $display("FAIL basic_reloaded: got %h want 02", v); end
    irq_ack = 1'b1;
    step();
    irq_ack = 1'b0;
    checks++;
    if (TIQ !== 1'b0) begin errors++; $display("FAIL ack_clear: got %b want 0", TIQ); end
    wait_tiq(4 * P, "ack_rearm_tiq");
    t2 = cyc;
    checks++;
    if (t2 - t1 != 3 * P) begin
      errors++; $display("FAIL ack_rearm_period: got %0d want %0d", t2 - t1, 3 * P);
    end
    irq_ack = 1'b1;
    step();
    irq_ack = 1'b0;
    wait_until(t2 + 3 * P - 1);
    checks++;
    if (TIQ !== 1'b0) begin errors++; $display("FAIL ack_pre_race: got %b want 0", TIQ); end
    irq_ack = 1'b1;
    step();
    irq_ack = 1'b0;
    checks++;
    if (TIQ !== 1'b1) begin errors++; $display("FAIL ack_race_set_wins: got %b want 1", TIQ); end
    step();
    checks++;
    if (TIQ !== 1'b1) begin errors++; $display("FAIL ack_level_hold: got %b want 1", TIQ); end
  endtask

  task automatic test_stop_restart();
    logic [7:0] v;
    int e0, e1, e2;
    do_reset();
    wr(1'b0, 8'h03);
    wr(1'b1, 8'h01);
    e0 = cyc;
    wait_until(e0 + 2 * P + 2);
    wr(1'b1, 8'h00);
    repeat (5000) step();
    rd(1'b0, v);
    checks++;
    if (v !== 8'h01) begin errors++; $display("FAIL stop_frozen: got %h want 01", v); end
    rd(1'b1, v);
    checks++;
    if (v !== 8'h00) begin errors++; $display("FAIL stop_en_rd: got %h want 00", v); end
    checks++;
    if (TIQ !== 1'b0) begin errors++; $display("FAIL stop_tiq: got %b want 0", TIQ); end
    wr(1'b1, 8'h01);
    e1 = cyc;
    rd(1'b0, v);
    checks++;
    if (v !== 8'h03) begin errors++; $display("FAIL restart_cnt: got %h want 03", v); end
    wait_tiq(5 * P, "restart_tiq");
    checks++;
    if (cyc - e1 != 4 * P) begin
      errors++; $display("FAIL restart_period: got %0d want %0d", cyc - e1, 4 * P);
    end
    e2 = cyc;
    irq_ack = 1'b1;
    step();
    irq_ack = 1'b0;
    wait_until(e2 + P + 5);
    wr(1'b1, 8'h01);
    wait_tiq(5 * P, "rewrite_tiq");
    checks++;
    if (cyc - e2 != 4 * P) begin
      errors++; $display("FAIL rewrite_phase: got %0d want %0d", cyc - e2, 4 * P);
    end
  endtask

  task automatic test_reload_race();
    logic [7:0] v;
    int e0;
    do_reset();
    wr(1'b0, 8'h01);
    wr(1'b1, 8'h01);
    e0 = cyc;
    wait_until(e0 + 2 * P - 1);
    wr(1'b0, 8'h7F);
    checks++;
    if (TIQ !== 1'b1) begin errors++; $display("FAIL race_tiq: got %b want 1", TIQ); end
    rd(1'b0, v);
    checks++;
    if (v !== 8'h01) begin errors++; $display("FAIL race_old_reload: got %h want 01", v); end
    wait_until(e0 + 4 * P - 1);
    rd(1'b0, v);
    checks++;
    if (v !== 8'h00) begin errors++; $display("FAIL race_pre_uf: got %h want 00", v); end
    step();
    rd(1'b0, v);
    checks++;
    if (v !== 8'h7F) begin errors++; $display("FAIL race_new_reload: got %h want 7f", v); end
    do_reset();
    wr(1'b0, 8'hFF);
    wr(1'b1, 8'h01);
    rd(1'b0, v);
    checks++;
    if (v !== 8'h7F) begin errors++; $display("FAIL reload_bit7: got %h want 7f", v); end
  endtask

  task automatic test_gating();
    logic [7:0] v;
    do_reset();
    CET_n = 1'b1; WE = 1'b1; RDY = 1'b1; addr0 = 1'b0; d_in = 8'h04;
    step();
    CET_n = 1'b0; RDY = 1'b0; addr0 = 1'b1; d_in = 8'h01;
    step();
    CET_n = 1'b1; WE = 1'b0; RDY = 1'b1; d_in = 8'h00;
    rd(1'b1, v);
    checks++;
    if (v !== 8'h00) begin errors++; $display("FAIL gate_rdy_en: got %h want 00", v); end
    wr(1'b1, 8'h01);
    rd(1'b0, v);
    checks++;
    if (v !== 8'h00) begin errors++; $display("FAIL gate_cet_reload: got %h want 00", v); end
    wr(1'b0, 8'h09);
    wr(1'b1, 8'h00);
    wr(1'b1, 8'h01);
    rd(1'b0, v);
    checks++;
    if (v !== 8'h09) begin errors++; $display("FAIL gate_cnt9: got %h want 09", v); end
    CET_n = 1'b0; RE = 1'b0; addr0 = 1'b0;
    #1;
    checks++;
    if (d_out !== 8'h00) begin errors++; $display("FAIL gate_re0: got %h want 00", d_out); end
    CET_n = 1'b1; RE = 1'b1;
    #1;
    checks++;
    if (d_out !== 8'h00) begin errors++; $display("FAIL gate_cet1: got %h want 00", d_out); end
    RE = 1'b0;
    wait_tiq(11 * P, "gate_tiq");
    CET_n = 1'b0; RE = 1'b1; RDY = 1'b1; addr0 = 1'b0;
    step();
    CET_n = 1'b1; RE = 1'b0;
`ifdef HUC_TIMER_ACK_ON_READ_EN
    checks++;
    if (TIQ !== 1'b0) begin errors++; $display("FAIL read_ack: got %b want 0", TIQ); end
`else
    checks++;
    if (TIQ !== 1'b1) begin errors++; $display("FAIL read_no_side_effect: got %b want 1", TIQ); end
`endif
  endtask

  initial begin
    test_reset();
    test_basic_and_ack();
    test_stop_restart();
    test_reload_race();
    test_gating();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
